// File: rtl/inputcond_debounce.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, debounce,
// polarity normalisation, press/release pulses and optional auto-repeat.
module inputcond_debounce #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] Ainput,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0]       DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]       DLY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0]       PER_LAST  = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam logic                REP_EN    = (REPEAT_DELAY > 0);
  localparam logic [CHANNELS-1:0] IDLE_PINS = {CHANNELS{(ACTIVE_LOW != 0)}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [CHANNELS-1:0] sync1_r, sync2_r;
  logic [CHANNELS-1:0] level_r, press_r, release_r;
  logic [DW-1:0]       dcnt_r [CHANNELS];
  state_t              state_r [CHANNELS];
  logic [RW-1:0]       rcnt_r [CHANNELS];

  logic [CHANNELS-1:0] pressed_s, level_next_s, rise_s, fall_s, rep_s;
  logic [DW-1:0]       dcnt_next_s [CHANNELS];
  state_t              state_next_s [CHANNELS];
  logic [RW-1:0]       rcnt_next_s [CHANNELS];

  // Polarity-normalised synchronised sample: 1 means pressed.
  assign pressed_s = sync2_r ^ IDLE_PINS;

  // Debounce: a new value must persist for DEBOUNCE_CYCLES samples.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_next_s[i] = level_r[i];
      dcnt_next_s[i]  = {DW{1'b0}};
      if (pressed_s[i] == level_r[i]) begin
        dcnt_next_s[i] = {DW{1'b0}};
      end else if (dcnt_r[i] == DB_LAST) begin
        level_next_s[i] = pressed_s[i];
        dcnt_next_s[i]  = {DW{1'b0}};
      end else begin
        dcnt_next_s[i] = dcnt_r[i] + DW'(1'b1);
      end
    end
    rise_s = level_next_s & ~level_r;
    fall_s = level_r & ~level_next_s;
  end

  // Auto-repeat next-state; a release always wins and suppresses a repeat.
  always_comb begin
    rep_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      state_next_s[i] = state_r[i];
      rcnt_next_s[i]  = rcnt_r[i];
      if (fall_s[i]) begin
        state_next_s[i] = ST_IDLE;
        rcnt_next_s[i]  = {RW{1'b0}};
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            rcnt_next_s[i] = {RW{1'b0}};
            if (rise_s[i] && REP_EN) begin
              state_next_s[i] = ST_DELAY;
            end else begin
              state_next_s[i] = ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (rcnt_r[i] == DLY_LAST) begin
              state_next_s[i] = ST_REPEAT;
              rcnt_next_s[i]  = {RW{1'b0}};
              rep_s[i]        = 1'b1;
            end else begin
              rcnt_next_s[i] = rcnt_r[i] + RW'(1'b1);
            end
          end
          ST_REPEAT: begin
            if (rcnt_r[i] == PER_LAST) begin
              rcnt_next_s[i] = {RW{1'b0}};
              rep_s[i]       = 1'b1;
            end else begin
              rcnt_next_s[i] = rcnt_r[i] + RW'(1'b1);
            end
          end
          default: begin
            state_next_s[i] = ST_IDLE;
            rcnt_next_s[i]  = {RW{1'b0}};
          end
        endcase
      end
    end
  end

  // State registers; synchroniser resets to the idle pin level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_r   <= IDLE_PINS;
      sync2_r   <= IDLE_PINS;
      level_r   <= {CHANNELS{1'b0}};
      press_r   <= {CHANNELS{1'b0}};
      release_r <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        dcnt_r[i]  <= {DW{1'b0}};
        state_r[i] <= ST_IDLE;
        rcnt_r[i]  <= {RW{1'b0}};
      end
    end else begin
      sync1_r   <= Ainput;
      sync2_r   <= sync1_r;
      level_r   <= level_next_s;
      press_r   <= rise_s | rep_s;
      release_r <= fall_s;
      for (int i = 0; i < CHANNELS; i++) begin
        dcnt_r[i]  <= dcnt_next_s[i];
        state_r[i] <= state_next_s[i];
        rcnt_r[i]  <= rcnt_next_s[i];
      end
    end
  end

  assign level    = level_r;
  assign press    = press_r;
  assign released = release_r;

endmodule

// File: tb/tb_inputcond_debounce.sv
// Scoreboard bench for inputcond_debounce: three builds (basic, auto-repeat,
// active-high); stimulus pushes expected events, a monitor pops and compares.
module tb_inputcond_debounce;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] ab = 2'b11, ar = 2'b11, ah = 2'b00;
  logic [1:0] lvl_b, prs_b, rel_b;
  logic [1:0] lvl_r, prs_r, rel_r;
  logic [1:0] lvl_h, prs_h, rel_h;
  logic [1:0] prs [3];
  logic [1:0] rel [3];

  int edge_n = 0;
  int total  = 0;
  int bad    = 0;

  typedef struct {
    int inst;
    int ch;
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  inputcond_debounce #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
                       .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) u_base (
    .clock(clock), .resetn(resetn), .Ainput(ab),
    .level(lvl_b), .press(prs_b), .released(rel_b));

  inputcond_debounce #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
                       .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) u_rep (
    .clock(clock), .resetn(resetn), .Ainput(ar),
    .level(lvl_r), .press(prs_r), .released(rel_r));

  inputcond_debounce #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
                       .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) u_hi (
    .clock(clock), .resetn(resetn), .Ainput(ah),
    .level(lvl_h), .press(prs_h), .released(rel_h));

  assign prs[0] = prs_b;
  assign prs[1] = prs_r;
  assign prs[2] = prs_h;
  assign rel[0] = rel_b;
  assign rel[1] = rel_r;
  assign rel[2] = rel_h;

  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input int inst, input int ch, input int kind, input int cyc);
    ev_t e;
    e.inst = inst;
    e.ch   = ch;
    e.kind = kind;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b at edge %0d", name, act, expv, edge_n);
    end
  endtask

  task automatic check_event(input int i, input int c, input int kd);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: inst=%0d ch=%0d at edge %0d, none expected",
               (kd == 0) ? "press" : "release", i, c, edge_n);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != i || e.ch != c || e.kind != kd || e.cyc != edge_n) begin
        bad++;
        $display("FAIL event: got inst=%0d ch=%0d kind=%0d edge=%0d expected inst=%0d ch=%0d kind=%0d edge=%0d",
                 i, c, kd, edge_n, e.inst, e.ch, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: every pulse seen must match the head of the expected queue.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (prs[i][c] && rel[i][c]) begin
          total++;
          bad++;
          $display("FAIL both_pulses: inst=%0d ch=%0d press=1 release=1 expected not both at edge %0d",
                   i, c, edge_n);
        end
        if (prs[i][c]) check_event(i, c, 0);
        if (rel[i][c]) check_event(i, c, 1);
      end
    end
  end

  initial begin
    int k;

    // reset state
    step(2);
    chk("rst_level_b", lvl_b, 2'b00);
    chk("rst_press_b", prs_b, 2'b00);
    chk("rst_release_b", rel_b, 2'b00);
    chk("rst_level_r", lvl_r, 2'b00);
    chk("rst_level_h", lvl_h, 2'b00);
    resetn = 1'b1;
    step(3);

    // basic press / release with exact latency
    ab[0] = 1'b0;
    k = edge_n + 1;
    push(0, 0, 0, k + 5);
    step(5);
    chk("press_lat_before", lvl_b, 2'b00);
    step(1);
    chk("press_lat_rise", lvl_b, 2'b01);
    step(10);
    ab[0] = 1'b1;
    k = edge_n + 1;
    push(0, 0, 1, k + 5);
    step(5);
    chk("release_lat_before", lvl_b, 2'b01);
    step(1);
    chk("release_lat_fall", lvl_b, 2'b00);
    step(5);

    // glitch of three samples: no level change, no event
    ab[0] = 1'b0;
    step(3);
    ab[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step(1);
      chk("glitch_level", lvl_b, 2'b00);
    end

    // bounce on ch1, then held low
    for (int j = 0; j < 10; j++) begin
      ab[1] = (j % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    ab[1] = 1'b0;
    k = edge_n + 1;
    push(0, 1, 0, k + 5);
    step(10);
    chk("bounce_level", lvl_b, 2'b10);

    // reset mid-debounce on ch0 while ch1 is held pressed
    ab[0] = 1'b0;
    step(3);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_level", lvl_b, 2'b00);
    chk("midrst_press", prs_b, 2'b00);
    chk("midrst_release", rel_b, 2'b00);
    step(3);
    resetn = 1'b1;
    k = edge_n + 1;
    push(0, 0, 0, k + 5);
    push(0, 1, 0, k + 5);
    step(5);
    chk("postrst_before", lvl_b, 2'b00);
    step(1);
    chk("postrst_level", lvl_b, 2'b11);
    step(5);

    // simultaneous release on both channels
    ab = 2'b11;
    k = edge_n + 1;
    push(0, 0, 1, k + 5);
    push(0, 1, 1, k + 5);
    step(10);
    chk("dual_release_level", lvl_b, 2'b00);

    // auto-repeat: 30-cycle hold
    ar[0] = 1'b0;
    k = edge_n + 1;
    push(1, 0, 0, k + 5);
    for (int t = k + 13; t < k + 35; t += 3) push(1, 0, 0, t);
    step(30);
    ar[0] = 1'b1;
    push(1, 0, 1, edge_n + 1 + 5);
    step(10);
    chk("repeat_level_after", lvl_r, 2'b00);

    // auto-repeat: release edge coincides with a due repeat pulse
    ar[0] = 1'b0;
    k = edge_n + 1;
    push(1, 0, 0, k + 5);
    push(1, 0, 0, k + 13);
    step(11);
    ar[0] = 1'b1;
    push(1, 0, 1, k + 16);
    step(10);

    // active-high build
    ah[0] = 1'b1;
    k = edge_n + 1;
    push(2, 0, 0, k + 5);
    step(8);
    chk("hi_level_pressed", lvl_h, 2'b01);
    ah[0] = 1'b0;
    k = edge_n + 1;
    push(2, 0, 1, k + 5);
    step(8);
    chk("hi_level_released", lvl_h, 2'b00);

    // every expected event must have been consumed
    step(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d left in queue expected 0 (head inst=%0d ch=%0d kind=%0d edge=%0d)",
               exp_q.size(), exp_q[0].inst, exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
